// File: rtl/button_pkg.sv
// Shared state encoding and default timing for button_event (50 MHz reference clock).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ / 2;   // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 10;  // 0.1 s
  localparam int unsigned DEF_CTR_WIDTH       = 25;
  localparam int unsigned DEF_COUNT_WIDTH     = 8;

endpackage

// File: rtl/button_timer.sv
// Hold-time up-counter with clear/enable and a match flag against a supplied terminal count.
module button_timer #(
  parameter int unsigned CTR_WIDTH = 25
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CTR_WIDTH-1:0] tc_i,
  output logic                 tc_hit_o
);

  logic [CTR_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= cnt_q + 1'b1;
  end

  assign tc_hit_o = (cnt_q == tc_i);

endmodule

// File: rtl/button_event.sv
// Debounced button level -> press/release/long-press/repeat pulses plus held level and press count.
// Auto-repeat in LONG is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned CTR_WIDTH     = DEF_CTR_WIDTH,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   btn_level_i,
  output logic                   press_o,
  output logic                   release_o,
  output logic                   release_short_o,
  output logic                   long_press_o,
  output logic                   repeat_o,
  output logic                   held_o,
  output logic [COUNT_WIDTH-1:0] press_count_o
);

  if (((64'd1 << CTR_WIDTH) <= 64'(LONG_CYCLES)) ||
      ((64'd1 << CTR_WIDTH) <= 64'(REPEAT_CYCLES))) begin : g_bad_width
    $error("button_event: CTR_WIDTH too narrow for LONG_CYCLES/REPEAT_CYCLES");
  end

  localparam logic [CTR_WIDTH-1:0] LONG_TC = CTR_WIDTH'(LONG_CYCLES - 1);

  state_e                 state_q;
  logic                   prev_q;
  logic                   press_q, release_q, rshort_q, long_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   rise, fall;
  logic                   tmr_clr, tmr_en, tc_hit;
  logic [CTR_WIDTH-1:0]   tc_val;

  assign rise = btn_level_i & ~prev_q;
  assign fall = ~btn_level_i & prev_q;

  // One counter serves both thresholds; the compare value follows the state.
  always_comb begin
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    tc_val  = LONG_TC;
    case (state_q)
      PRESSED: begin
        tmr_clr = fall | tc_hit;
        tmr_en  = 1'b1;
      end
`ifdef BUTTON_EVENT_REPEAT_EN
      LONG: begin
        tc_val  = CTR_WIDTH'(REPEAT_CYCLES - 1);
        tmr_clr = fall | tc_hit;
        tmr_en  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  button_timer #(.CTR_WIDTH(CTR_WIDTH)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_i     (tc_val),
    .tc_hit_o (tc_hit)
  );

`ifdef BUTTON_EVENT_REPEAT_EN
  logic repeat_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      release_q <= 1'b0;
      rshort_q <= 1'b0;
      long_q   <= 1'b0;
      count_q  <= '0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      prev_q    <= btn_level_i;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rshort_q  <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: if (rise) begin
          state_q <= PRESSED;
          press_q <= 1'b1;
          count_q <= count_q + 1'b1;
        end
        // Release has priority over a threshold hit in the same cycle.
        PRESSED: if (fall) begin
          state_q   <= IDLE;
          release_q <= 1'b1;
          rshort_q  <= 1'b1;
        end else if (tc_hit) begin
          state_q <= LONG;
          long_q  <= 1'b1;
        end
        LONG: if (fall) begin
          state_q   <= IDLE;
          release_q <= 1'b1;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (tc_hit) begin
          repeat_q <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign press_o         = press_q;
  assign release_o       = release_q;
  assign release_short_o = rshort_q;
  assign long_press_o    = long_q;
  assign held_o          = prev_q;
  assign press_count_o   = count_q;
`ifdef BUTTON_EVENT_REPEAT_EN
  assign repeat_o        = repeat_q;
`else
  assign repeat_o        = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=3; repeat expectations follow BUTTON_EVENT_REPEAT_EN.
module tb_button_event;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       press, rel, rshort, lng, rep, held;
  logic [7:0] cnt;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] cnt_m  = 8'd0;

  always #5 clk = ~clk;

  button_event #(
    .CTR_WIDTH(4), .LONG_CYCLES(8), .REPEAT_CYCLES(3), .COUNT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_level_i(btn),
    .press_o(press), .release_o(rel), .release_short_o(rshort),
    .long_press_o(lng), .repeat_o(rep), .held_o(held), .press_count_o(cnt)
  );

  // {held, press, release, release_short, long_press, repeat}
  wire [5:0] obs = {held, press, rel, rshort, lng, rep};

  localparam logic [4:0] P  = 5'b10000;
  localparam logic [4:0] RS = 5'b01100;
  localparam logic [4:0] RL = 5'b01000;
  localparam logic [4:0] L  = 5'b00010;
  localparam logic [4:0] R  = 5'b00001;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst = 1'b1; btn = 1'b0;
    step(); step();
    n_chk++;
    if (obs !== 6'b0 || cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_active: got %b cnt %0d expected 000000 cnt 0", obs, cnt);
    end
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      e = 6'b0;
      n_chk++;
      if (obs !== e || cnt !== 8'd0) begin
        n_fail++; $display("FAIL reset_idle j=%0d: got %b cnt %0d expected %b cnt 0", j, obs, cnt, e);
      end
    end
  endtask

  task automatic test_short_press();
    logic [5:0] e;
    btn = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      e = {1'b1, (j == 1) ? P : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL short_hold j=%0d: got %b expected %b", j, obs, e);
      end
    end
    cnt_m = cnt_m + 8'd1;
    btn = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      e = {1'b0, (j == 1) ? RS : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL short_release j=%0d: got %b expected %b", j, obs, e);
      end
    end
    n_chk++;
    if (cnt !== cnt_m) begin
      n_fail++; $display("FAIL short_count: got %0d expected %0d", cnt, cnt_m);
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] e;
    logic [4:0] p;
    btn = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      p = 5'b0;
      if (j == 1) p = P;
      if (j == 9) p = L;
      if (REP_ON && (j == 12 || j == 15 || j == 18)) p = R;
      e = {1'b1, p};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL long_hold j=%0d: got %b expected %b", j, obs, e);
      end
    end
    cnt_m = cnt_m + 8'd1;
    btn = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      e = {1'b0, (j == 1) ? RL : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL long_release j=%0d: got %b expected %b", j, obs, e);
      end
    end
    n_chk++;
    if (cnt !== cnt_m) begin
      n_fail++; $display("FAIL long_count: got %0d expected %0d", cnt, cnt_m);
    end
  endtask

  task automatic test_fall_at_threshold();
    logic [5:0] e;
    btn = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      e = {1'b1, (j == 1) ? P : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL thr_hold j=%0d: got %b expected %b", j, obs, e);
      end
    end
    cnt_m = cnt_m + 8'd1;
    btn = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      e = {1'b0, (j == 1) ? RS : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL thr_release j=%0d: got %b expected %b", j, obs, e);
      end
    end
  endtask

  task automatic test_count_wrap();
    for (int k = 0; k < 253; k++) begin
      btn = 1'b1; step(); step();
      btn = 1'b0; step(); step();
      cnt_m = cnt_m + 8'd1;
      n_chk++;
      if (cnt !== cnt_m) begin
        n_fail++; $display("FAIL wrap_count k=%0d: got %0d expected %0d", k, cnt, cnt_m);
      end
    end
    n_chk++;
    if (cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_zero: got %0d expected 0", cnt);
    end
  endtask

  task automatic test_reset_in_long();
    logic [5:0] e;
    logic [4:0] p;
    btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      p = 5'b0;
      if (j == 1) p = P;
      if (j == 9) p = L;
      if (REP_ON && j == 12) p = R;
      e = {1'b1, p};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL rstlong_hold j=%0d: got %b expected %b", j, obs, e);
      end
    end
    rst = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step();
      n_chk++;
      if (obs !== 6'b0 || cnt !== 8'd0) begin
        n_fail++; $display("FAIL rstlong_reset j=%0d: got %b cnt %0d expected 000000 cnt 0", j, obs, cnt);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      step();
      e = {1'b1, (j == 1) ? P : 5'b0};
      n_chk++;
      if (obs !== e || cnt !== 8'd1) begin
        n_fail++; $display("FAIL rstlong_repress j=%0d: got %b cnt %0d expected %b cnt 1", j, obs, cnt, e);
      end
    end
    btn = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      step();
      e = {1'b0, (j == 1) ? RS : 5'b0};
      n_chk++;
      if (obs !== e) begin
        n_fail++; $display("FAIL rstlong_release j=%0d: got %b expected %b", j, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_fall_at_threshold();
    test_count_wrap();
    test_reset_in_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the button debouncer/synchroniser.
- Consumes its clean, stable "pressed" level and turns it into one-cycle event pulses: press, release, long-press and auto-repeat.
- Also exposes a held level and a wrapping press counter.
- Feeds UI/control logic on the Mojo top level (menu stepping, LED modes, counters).

Parameters:
- CTR_WIDTH, 25, width of the internal hold-time counter; must satisfy 2^CTR_WIDTH > max(LONG_CYCLES, REPEAT_CYCLES).
- LONG_CYCLES, 25000000, cycles of continuous hold after press before long_press fires (0.5 s at 50 MHz); >= 2.
- REPEAT_CYCLES, 5000000, period in cycles between repeat pulses once long-press is reached; >= 2.
- COUNT_WIDTH, 8, width of press_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- btn_level  in  1  debounced level, 1 = pressed; already synchronous to clk.
- press  out  1  one-cycle pulse on a new press.
- release  out  1  one-cycle pulse on release.
- release_short  out  1  qualifies release: 1 when release occurs before long_press fired.
- long_press  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat  out  1  one-cycle pulse every REPEAT_CYCLES while held past long-press.
- held  out  1  registered copy of btn_level.
- press_count  out  COUNT_WIDTH  number of presses since reset, wrapping.

Behaviour:
- All outputs are registered.
- Reset: state = IDLE, ctr = 0, prev_q = 0, all outputs 0. Reset wins over any simultaneous input.
- A button held through reset release produces a press pulse in the cycle after reset deasserts. prev_q = 0 makes this deterministic.
- Edge detect: rise = btn_level & ~prev_q; fall = ~btn_level & prev_q; prev_q <= btn_level each cycle. held = prev_q.
- Latency: every pulse output is high for exactly the one cycle following the clk edge at which the causing condition was sampled.
- FSM states: IDLE, PRESSED, LONG.
  - IDLE: on rise -> PRESSED, ctr <= 0, press <= 1, press_count <= press_count + 1 (modulo 2^COUNT_WIDTH, 255 -> 0 at default).
  - PRESSED: on fall -> IDLE, release <= 1, release_short <= 1, ctr <= 0.
    - Else if ctr == LONG_CYCLES-1 -> LONG, long_press <= 1, ctr <= 0.
    - Else ctr <= ctr + 1.
  - LONG: on fall -> IDLE, release <= 1, release_short <= 0, ctr <= 0.
    - Else repeat behaviour per the optional feature below.
- Simultaneous events: a fall on the same cycle ctr reaches its threshold means release wins; no long_press or repeat is emitted.
- Because the debouncer guarantees a stable level, rise and fall never occur in consecutive cycles. The block must nevertheless handle 1-cycle glitches per the rules above (press then release, two cycles apart).
- press and long_press never assert in the same cycle. release never asserts with press, long_press or repeat.
- ctr never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1 and never wraps.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: in LONG, if ctr == REPEAT_CYCLES-1 then repeat <= 1 and ctr <= 0; else ctr <= ctr + 1. The first repeat comes REPEAT_CYCLES cycles after long_press.
- Undefined: repeat is tied to 0 and ctr holds at 0 in LONG. There is no repeat logic and no REPEAT_CYCLES compare.

Decomposition:
- Package button_pkg holds:
  - a state typedef (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2);
  - default timing constants: 50 MHz clock, 0.5 s long-press, 0.1 s repeat, expressed in cycles.
- One natural sub-module, button_timer: a CTR_WIDTH up-counter with clear, enable and a terminal-count compare input. It is reused for the long-press and repeat thresholds.

Test Plan:
- Use LONG_CYCLES=8, REPEAT_CYCLES=3, REPEAT_EN defined.
- Reset with btn_level=0, then hold btn_level=0 for 20 cycles -> all outputs 0, press_count=0.
- btn_level 0->1 sampled at edge N, held 4 cycles, then 0 -> press high only in cycle N+1; release and release_short high one cycle after the fall is sampled; press_count=1; no long_press.
- Hold btn_level=1 for 20 cycles -> press at N+1, long_press at N+9, repeat at N+12, N+15, N+18; on release, release=1 and release_short=0.
- Fall sampled on the exact cycle ctr==LONG_CYCLES-1 -> release with release_short=1; long_press never asserts.
- 256 short presses -> press_count wraps to 0; assert rst mid-hold in LONG -> next cycle all outputs 0, state IDLE, no release pulse.
- Build with the macro undefined, hold 20 cycles -> long_press at N+9, repeat stays 0.
